// File: rtl/nes_joypad_serializer.sv
// Purpose : NES controller-port serializer. It synchronises button state, applies autofire gating,
//           latches on strobe, and shifts one bit per falling joy_clk edge for each port.
// Latency : btn_in reaches eff after 2 clk. joy_data updates on the edge that first samples joy_clk low.
// Backpres: none. Strobe overrides shifting, and extra reads past BTN_W return FILL_BIT.
//
// Ports:
//   clk       system clock (clk3 domain)
//   resetn    asynchronous active-low reset
//   btn_in    raw button state, pressed=1, port p at [p*BTN_W +: BTN_W], async to clk
//   af_mask   per-button autofire enable, same packing, sync to clk
//   strobe    level-sensitive latch strobe from the NES core
//   joy_clk   per-port read clock, sync to clk
//   joy_data  per-port serial bit (shift register bit 0, registered)
//   joy_done  per-port one-cycle pulse after the BTN_W-th bit is consumed
//   af_phase  current autofire phase
module nes_joypad_serializer #(
  parameter int   NUM_PORTS      = 2,
  parameter int   BTN_W          = 8,
  parameter logic FILL_BIT       = 1'b1,
  parameter int   AF_HALF_CYCLES = 630_000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_PORTS*BTN_W-1:0] btn_in,
  input  logic [NUM_PORTS*BTN_W-1:0] af_mask,
  input  logic                       strobe,
  input  logic [NUM_PORTS-1:0]       joy_clk,
  output logic [NUM_PORTS-1:0]       joy_data,
  output logic [NUM_PORTS-1:0]       joy_done,
  output logic                       af_phase
);

  localparam int TOT_W = NUM_PORTS * BTN_W;
  localparam int CW    = $clog2(BTN_W + 1);
  localparam int AW    = (AF_HALF_CYCLES > 2) ? $clog2(AF_HALF_CYCLES) : 1;

  logic [TOT_W-1:0] btn_s1;
  logic [TOT_W-1:0] btn_s2;
  logic [TOT_W-1:0] eff;
  logic [AW-1:0]    af_cnt;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // The autofire phase starts at 1, so a freshly pressed autofire button reads pressed first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AW'(AF_HALF_CYCLES - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + AW'(1);
    end
  end

  // A button without autofire passes straight through. A button with autofire is gated by the phase.
  always_comb begin
    eff = btn_s2 & (~af_mask | {TOT_W{af_phase}});
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [BTN_W-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_clk;
    logic             done_q;
    logic             fall;

    always_comb begin
      fall = ~joy_clk[p] & last_clk;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sreg     <= '0;
        cnt      <= '0;
        last_clk <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        // Edge history is tracked even while strobe is high. An edge masked by strobe is therefore not
        // replayed once strobe drops.
        last_clk <= joy_clk[p];
        if (strobe) begin
          sreg   <= eff[p*BTN_W +: BTN_W];
          cnt    <= '0;
          done_q <= 1'b0;
        end else if (fall) begin
          sreg   <= {FILL_BIT, sreg[BTN_W-1:1]};
          if (cnt != CW'(BTN_W))
            cnt  <= cnt + CW'(1);
          // The done pulse fires only on the shift that reaches BTN_W. A saturated counter stays quiet.
          done_q <= (cnt == CW'(BTN_W - 1));
        end else begin
          done_q <= 1'b0;
        end
      end
    end

    assign joy_data[p] = sreg[0];
    assign joy_done[p] = done_q;
  end

endmodule

// File: tb/tb_nes_joypad_serializer.sv
module tb_nes_joypad_serializer;

  localparam int NP = 2;
  localparam int BW = 8;
  localparam int AF = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NP*BW-1:0] btn_in;
  logic [NP*BW-1:0] af_mask;
  logic            strobe;
  logic [NP-1:0]   joy_clk;
  logic [NP-1:0]   joy_data;
  logic [NP-1:0]   joy_done;
  logic            af_phase;

  int n_checks = 0;
  int n_pass   = 0;

  nes_joypad_serializer #(
    .NUM_PORTS(NP), .BTN_W(BW), .FILL_BIT(1'b1), .AF_HALF_CYCLES(AF)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .af_mask(af_mask), .strobe(strobe),
    .joy_clk(joy_clk), .joy_data(joy_data), .joy_done(joy_done), .af_phase(af_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;      // 1: strobe-load btn0/btn1, then check; 0: one edge per edge_m (0 = idle cycle)
    logic [7:0] btn0;
    logic [7:0] btn1;
    logic [1:0] edge_m;
    logic [1:0] exp_data;
    logic [1:0] exp_done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs change, and outputs are sampled, 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1);
    btn_in = {b1, b0};
    strobe = 1'b1;
    repeat (3) tick();
    strobe = 1'b0;
    tick();
  endtask

  task automatic give_edge(input logic [1:0] m);
    joy_clk = m;
    tick();
    joy_clk = 2'b00;
    tick();
  endtask

  // Reads port 0 holding 8'h85 bit by bit. Starts with bit 0 already on joy_data.
  task automatic read85(input string tag);
    logic [7:0] v;
    v = 8'h85;
    chk({tag, "_bit0"}, 32'(joy_data[0]), 32'(v[0]));
    for (int i = 1; i <= 8; i++) begin
      give_edge(2'b01);
      chk($sformatf("%s_data%0d", tag, i), 32'(joy_data[0]), (i < 8) ? 32'(v[i]) : 32'd1);
      chk($sformatf("%s_done%0d", tag, i), 32'(joy_done[0]), (i == 8) ? 32'd1 : 32'd0);
    end
  endtask

  function automatic logic ph(input int k);
    return ((k / AF) % 2) == 0;
  endfunction

  initial begin
    // Basic read: 0x85 on port 0, with port 1 idle at 0.
    tbl.push_back('{1'b1, 8'h85, 8'h00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b01}); // 8th edge: done pulse
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 2'b01, 2'b00}); // pulse lasts one cycle
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00}); // edge 9 reads fill
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00}); // edge 10 reads fill
    // Independent ports: port0=FF, port1=00.
    tbl.push_back('{1'b1, 8'hFF, 8'h00, 2'b00, 2'b01, 2'b00});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 2'b01, 2'b01}); // port0 reaches 8 edges
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 2'b11, 2'b10}); // port1 reaches 8 edges, fill

    resetn  = 1'b0;
    btn_in  = '0;
    af_mask = '0;
    strobe  = 1'b0;
    joy_clk = '0;
    repeat (3) tick();
    chk("rst_data", 32'(joy_data), 32'd0);
    chk("rst_done", 32'(joy_done), 32'd0);
    chk("rst_phase", 32'(af_phase), 32'd1);

    // Release reset. Autofire on port0 bit0 with strobe held high, so joy_data follows the phase.
    resetn     = 1'b1;
    btn_in     = 16'h0001;
    af_mask    = 16'h0001;
    strobe     = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("af_phase_k%0d", k), 32'(af_phase), 32'(ph(k)));
      chk($sformatf("af_data_k%0d", k), 32'(joy_data[0]), (k < 3) ? 32'd0 : 32'(ph(k - 1)));
    end
    af_mask = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("af_off_k%0d", k), 32'(joy_data[0]), 32'd1);
    end
    strobe = 1'b0;
    tick();

    // Table-driven read and port-independence vectors.
    foreach (tbl[i]) begin
      if (tbl[i].load) load(tbl[i].btn0, tbl[i].btn1);
      else if (tbl[i].edge_m == 2'b00) tick();
      else give_edge(tbl[i].edge_m);
      chk($sformatf("tbl%0d_data", i), 32'(joy_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_done", i), 32'(joy_done), 32'(tbl[i].exp_done));
    end

    // A falling edge while strobe is high is ignored, and the counter stays at 0.
    btn_in  = 16'h0085;
    strobe  = 1'b1;
    repeat (3) tick();
    joy_clk = 2'b01;
    tick();
    joy_clk = 2'b00;
    tick();
    chk("strb_edge_data", 32'(joy_data[0]), 32'd1);
    strobe = 1'b0;
    tick();
    read85("strb_edge");

    // Strobe in the middle of a read reloads the full value.
    load(8'h85, 8'h00);
    for (int i = 0; i < 3; i++) give_edge(2'b01);
    chk("mid_before", 32'(joy_data[0]), 32'd0);
    load(8'h85, 8'h00);
    read85("mid_strb");

    // Reset mid-read: outputs clear, no done pulse, and the next read works normally.
    load(8'h85, 8'h00);
    for (int i = 0; i < 4; i++) give_edge(2'b01);
    resetn = 1'b0;
    #1;
    chk("mrst_data", 32'(joy_data), 32'd0);
    chk("mrst_done", 32'(joy_done), 32'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mrst_idle_done%0d", i), 32'(joy_done), 32'd0);
      chk($sformatf("mrst_idle_data%0d", i), 32'(joy_data), 32'd0);
    end
    load(8'h85, 8'h00);
    read85("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nes_joypad_serializer.md
# nes_joypad_serializer

Parametrised NES controller-port serializer for NUM_PORTS pads. It synchronises parallel button state from the controller receivers and applies per-button autofire gating. It latches the state on the CPU strobe and shifts one bit out per falling edge of each port's joypad clock. The block sits between the Dualshock receivers and the NES core's $4016/$4017 read path, replacing ad-hoc per-port shift logic and standalone autofire instances.

## Interface
- NUM_PORTS, 2, number of controller ports (1..4)
- BTN_W, 8, buttons per port; bit 0 is shifted out first (NES order: A,B,Select,Start,Up,Down,Left,Right)
- FILL_BIT, 1'b1, value shifted into the MSB on each shift; returned once all BTN_W bits have been read
- AF_HALF_CYCLES, 630_000, clk cycles per autofire phase (≈30 Hz at 37.8 MHz); minimum 2
- clk  in  1  system clock (clk3 domain)
- resetn  in  1  asynchronous, active-low reset
- btn_in  in  NUM_PORTS*BTN_W  pressed=1; port p occupies [p*BTN_W +: BTN_W]; asynchronous to clk
- af_mask  in  NUM_PORTS*BTN_W  1 = autofire enabled for that button; same packing; synchronous to clk
- strobe  in  1  NES joypad strobe, level-sensitive
- joy_clk  in  NUM_PORTS  per-port read clock from the NES core, synchronous to clk
- joy_data  out  NUM_PORTS  current serial bit per port = shift register bit 0
- joy_done  out  NUM_PORTS  one-cycle pulse when the BTN_W-th bit of a port has been consumed
- af_phase  out  1  current autofire phase, for debug and LEDs

## Operation
- Synchroniser: btn_in passes through two flops (btn_s1, btn_s2), both reset to 0.
- Autofire timer: af_cnt counts 0..AF_HALF_CYCLES-1 and wraps. af_phase toggles on each wrap. Reset: af_cnt=0, af_phase=1, so a newly pressed autofire button reads pressed first.
- Effective state per bit: eff = btn_s2 & (~af_mask | {af_phase}).
- Per port p, the block holds a BTN_W-bit sreg[p], a registered last_clk[p], and a bit counter cnt[p] of width $clog2(BTN_W+1).
- Strobe high: every cycle, sreg[p] <= eff[p] and cnt[p] <= 0. Shift requests are ignored, including a simultaneous falling edge.
- Strobe low, falling edge (joy_clk[p]==0 and last_clk[p]==1): sreg[p] <= {FILL_BIT, sreg[p][BTN_W-1:1]}. cnt[p] increments, saturating at BTN_W.
- joy_done[p] is 1 for exactly the cycle after a shift that moves cnt[p] from BTN_W-1 to BTN_W. Once saturated, cnt[p] produces no further pulses.
- last_clk[p] <= joy_clk[p] every cycle, independent of strobe.
- Ports are fully independent. Edges on several ports in the same cycle all shift.
- Reset (any time, including mid-read):
  - sreg = 0, so joy_data = 0.
  - cnt = 0, last_clk = 0, joy_done = 0.
  - Synchronisers cleared.
  - The next strobe reloads normally.

## Timing
- btn_in to eff: 2 clk cycles, plus up to one autofire phase of gating.
- Strobe reload: sreg reflects the eff sampled at each rising clk edge while strobe=1. The value frozen is the eff from the last cycle strobe was high.
- Shift latency: sreg updates on the clk edge at which joy_clk is first sampled 0 after being 1. joy_data is valid immediately after that edge, one cycle after joy_clk falls.
- Minimum joy_clk low/high time: 1 clk cycle each. A 1-cycle high pulse still yields exactly one shift.
- joy_data is a direct register output with no combinational path from any input.
- af_phase period: 2*AF_HALF_CYCLES cycles. Toggles land exactly at af_cnt wrap.

## Test plan
- Reset/idle: hold resetn=0, then release with strobe=0 → joy_data=0, joy_done=0, af_phase=1. With btn_in=0, the af_phase first toggle occurs AF_HALF_CYCLES cycles after release.
- Basic read (BTN_W=8, port 0 btn=8'b1000_0101, af_mask=0):
  - Wait 3 cycles, strobe 1→0, then give 8 falling edges.
  - Required joy_data sequence, bit 0 first: 1,0,1,0,0,0,0,1.
  - joy_done pulses once after the 8th edge.
  - Edges 9 and 10 read 1 (FILL_BIT).
- Strobe priority: strobe=1 with a simultaneous joy_clk falling edge → no shift, cnt stays 0, joy_data = eff bit 0. Mid-read strobe after 3 shifts → cnt=0 and the full value reloads.
- Autofire (AF_HALF_CYCLES=4, btn bit0=1, af_mask bit0=1):
  - Strobe each cycle; joy_data alternates 1 for 4 cycles, then 0 for 4 cycles.
  - With af_mask=0, joy_data stays 1.
- Independent ports (NUM_PORTS=2, port0=8'hFF, port1=8'h00):
  - Edges on port 0 only → port 1 joy_data stays 0 and cnt1 stays 0.
  - Simultaneous edges on both ports → both shift in the same cycle.
- Reset mid-operation: after 4 shifts, pulse resetn low for 1 cycle → joy_data=0 and no joy_done pulse. Next strobe + 8 edges reproduce the basic-read sequence.
